// File: rtl/elliptic_curve_structs.sv
// Shared secp256k1 types, constants and small helpers used by the point arithmetic blocks.
package elliptic_curve_structs;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } curve_point_t;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int           CURVE_B  = 7;
  localparam logic [255:0] SQRT_EXP = (P + 256'd1) >> 2;
  localparam logic [7:0]   PFX_EVEN = 8'h02;
  localparam logic [7:0]   PFX_ODD  = 8'h03;

  // 2^256 mod P: lets the multiplier fold the high part back without a divider
  localparam logic [32:0]  P_FOLD     = 33'h1_0000_03D1;
  localparam int           MM_DIGIT_W = 64;
  localparam int           MULT_LAT   = 256 / MM_DIGIT_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_CUBE_SQ, S_CUBE_MUL, S_ADDB, S_EXP_INIT,
    S_EXP_SQ, S_EXP_MUL, S_VERIFY, S_PARITY, S_FINISH, S_FAIL
  } pd_state_e;

  function automatic logic [255:0] add_b_mod_p(input logic [255:0] v);
    logic [256:0] s;
    s = 257'(v) + 257'(CURVE_B);
    if (s >= 257'(P)) s = s - 257'(P);
    return s[255:0];
  endfunction

endpackage

// File: rtl/point_decompress_if.sv
// Request/response bundle between a key consumer and point_decompress.
interface point_decompress_if;
  import elliptic_curve_structs::*;

  logic         Start;
  logic [263:0] comp_in;
  curve_point_t out_point;
  logic         Valid;
  logic         Done;
  logic         Busy;

  modport master (output Start, comp_in, input out_point, Valid, Done, Busy);
  modport slave  (input Start, comp_in, output out_point, Valid, Done, Busy);
endinterface

// File: rtl/mod_mult_p.sv
// a*b mod P, MM_DIGIT_W bits of b per cycle; done pulses MULT_LAT cycles after start.
module mod_mult_p
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  logic         start_i,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic         done_o,
  output logic [255:0] res_o
);
  localparam int NDIG  = 256 / MM_DIGIT_W;
  localparam int CNT_W = $clog2(NDIG);
  localparam int SW    = 256 + MM_DIGIT_W + 1;
  localparam int HW    = SW - 256 + 33;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  logic [255:0]     a_q, b_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, done_q;

  // acc*2^D + a*digit, folded once via 2^256 = P_FOLD, then one conditional
  // subtract: any fold result >= 2^256 drops below P after that subtract.
  function automatic logic [255:0] mm_step(input logic [255:0] acc,
                                           input logic [255:0] a,
                                           input logic [MM_DIGIT_W-1:0] dig);
    logic [SW-1:0] s;
    logic [HW-1:0] hc;
    logic [256:0]  r;
    s  = (SW'(acc) << MM_DIGIT_W) + SW'(a) * SW'(dig);
    hc = HW'(s[SW-1:256]) * HW'(P_FOLD);
    r  = 257'(s[255:0]) + 257'(hc);
    if (r >= 257'(P)) r = r - 257'(P);
    return r[255:0];
  endfunction

  always_ff @(posedge clk) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        a_q   <= a_i;
        b_q   <= b_i << MM_DIGIT_W;
        acc_q <= mm_step(256'd0, a_i, b_i[255 -: MM_DIGIT_W]);
        cnt_q <= CNT_W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= mm_step(acc_q, a_q, b_q[255 -: MM_DIGIT_W]);
        b_q   <= b_q << MM_DIGIT_W;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign res_o  = acc_q;
endmodule

// File: rtl/reg_256.sv
// Enabled register with synchronous clear; width defaults to one field element.
module reg_256 #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (Reset)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/point_decompress.sv
// SEC1 compressed secp256k1 key -> affine point; y = (x^3+7)^((P+1)/4) with parity fix.
module point_decompress
  import elliptic_curve_structs::*;
#(
  parameter int EXP_MSB = 253
) (
  input logic               clk,
  input logic               Reset,
  point_decompress_if.slave bus
);
  pd_state_e    state_q;
  logic [7:0]   i_q, pfx_q;
  logic [255:0] x_q, acc_q, rhs_q, m_a_q, m_b_q, m_res;
  logic         m_start_q, m_done, on_curve_q, accept;
  curve_point_t out_q;
  logic         valid_q, done_q, busy_q;

  assign accept = (state_q == S_IDLE) && bus.Start;

  reg_256 #(.WIDTH(256)) u_x_reg (
    .clk(clk), .Reset(Reset), .en_i(accept), .d_i(bus.comp_in[255:0]), .q_o(x_q)
  );
  reg_256 #(.WIDTH(8)) u_pfx_reg (
    .clk(clk), .Reset(Reset), .en_i(accept), .d_i(bus.comp_in[263:256]), .q_o(pfx_q)
  );

  mod_mult_p u_mult (
    .clk(clk), .Reset(Reset), .start_i(m_start_q), .a_i(m_a_q), .b_i(m_b_q),
    .done_o(m_done), .res_o(m_res)
  );

  // Every multiply is issued on the edge that enters its state, so each one
  // occupies exactly MULT_LAT+1 cycles including the completion cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      acc_q      <= '0;
      rhs_q      <= '0;
      m_a_q      <= '0;
      m_b_q      <= '0;
      m_start_q  <= 1'b0;
      on_curve_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      m_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          busy_q  <= 1'b1;
          out_q   <= '0;
          valid_q <= 1'b0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if ((pfx_q != PFX_EVEN && pfx_q != PFX_ODD) || x_q >= P) begin
            done_q  <= 1'b1;
            state_q <= S_FAIL;
          end else begin
            m_start_q <= 1'b1;
            m_a_q     <= x_q;
            m_b_q     <= x_q;
            state_q   <= S_CUBE_SQ;
          end
        end
        S_CUBE_SQ: if (m_done) begin
          m_start_q <= 1'b1;
          m_a_q     <= m_res;
          m_b_q     <= x_q;
          state_q   <= S_CUBE_MUL;
        end
        S_CUBE_MUL: if (m_done) begin
          acc_q   <= m_res;
          state_q <= S_ADDB;
        end
        S_ADDB: begin
          rhs_q   <= add_b_mod_p(acc_q);
          state_q <= S_EXP_INIT;
        end
        // The top exponent bit turns acc=1 into acc=rhs without a multiply.
        S_EXP_INIT: begin
          acc_q     <= rhs_q;
          i_q       <= 8'(EXP_MSB - 1);
          m_start_q <= 1'b1;
          m_a_q     <= rhs_q;
          m_b_q     <= rhs_q;
          state_q   <= S_EXP_SQ;
        end
        S_EXP_SQ: if (m_done) begin
          acc_q     <= m_res;
          m_start_q <= 1'b1;
          m_a_q     <= m_res;
          if (SQRT_EXP[i_q]) begin
            m_b_q   <= rhs_q;
            state_q <= S_EXP_MUL;
          end else begin
            m_b_q <= m_res;
            if (i_q == '0) state_q <= S_VERIFY;
            else           i_q     <= i_q - 1'b1;
          end
        end
        S_EXP_MUL: if (m_done) begin
          acc_q     <= m_res;
          m_start_q <= 1'b1;
          m_a_q     <= m_res;
          m_b_q     <= m_res;
          if (i_q == '0) begin
            state_q <= S_VERIFY;
          end else begin
            i_q     <= i_q - 1'b1;
            state_q <= S_EXP_SQ;
          end
        end
        // The verdict is applied in Parity so every curve-checked key has one latency.
        S_VERIFY: if (m_done) begin
          on_curve_q <= (m_res == rhs_q);
          state_q    <= S_PARITY;
        end
        S_PARITY: begin
          done_q <= 1'b1;
          if (!on_curve_q || (acc_q[0] != pfx_q[0] && acc_q == '0)) begin
            state_q <= S_FAIL;
          end else begin
            valid_q   <= 1'b1;
            out_q.x   <= x_q;
            out_q.y   <= (acc_q[0] == pfx_q[0]) ? acc_q : P - acc_q;
            state_q   <= S_FINISH;
          end
        end
        S_FINISH, S_FAIL: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_point = out_q;
  assign bus.Valid     = valid_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = busy_q;
endmodule

// File: doc/point_decompress.md
Name: point_decompress

Overview:
Decodes a 33-byte SEC1 compressed secp256k1 public key (prefix byte plus x) into the full affine point (x, y). It is the receive-side counterpart of the scalar-multiply point generator: the generator's output is transmitted compressed, and this block recovers y as (x^3+7)^((p+1)/4) mod p. It checks that the encoding is well formed, that y^2 = x^3+7, and it fixes the parity of y.

Parameters:
EXP_MSB, 253, index of the most significant set bit of the exponent E = (p+1)/4.

Ports:
clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request; sampled only in Idle
comp_in  input  264  bits [263:256] = prefix byte; bits [255:0] = x
out_point  output  512  curve_point_t {x,y}; valid when Done=1
Valid  output  1  1 = decoded point is on the curve; qualified by Done
Done  output  1  one-cycle completion pulse
Busy  output  1  high from the cycle after Start until the Done cycle, inclusive

Behaviour:
- Reset values: out_point=0, Valid=0, Done=0, Busy=0, state=Idle. Reset is honoured in any state, including mid-exponentiation; the in-flight multiplier is reset too and no Done is produced.
- Idle: on Start, latch prefix and x into internal registers and go to Check. comp_in is don't-care after that cycle.
- Start is ignored while Busy=1.
- Check (1 cycle): invalid if prefix is not 0x02 or 0x03, or if x >= P. An invalid key goes to Fail.
- Compute x^2, then x^3, using the mod_mult_p handshake (pulse mult_start, wait for mult_done).
- AddB: rhs = x^3 + 7 mod p, with one conditional subtraction of P. Use 257-bit intermediate arithmetic.
- Exponentiation: acc = 1, bit index i = EXP_MSB.
  - ExpSq: acc = acc*acc. Skip ExpSq when i = EXP_MSB.
  - ExpMul: if E[i]=1, acc = acc*rhs.
  - Then decrement i. After i = 0 completes, go to Verify.
- Verify: t = acc*acc. If t != rhs, go to Fail (x is not on the curve).
- Parity:
  - If acc[0] == prefix[0], y = acc.
  - Else if acc == 0, go to Fail.
  - Else y = P - acc.
- Finish (1 cycle): out_point = {x, y}, Valid=1, Done=1, then Idle.
- Fail (1 cycle): out_point = 0, Valid=0, Done=1, then Idle.
- out_point and Valid hold their values after Done until the next accepted Start, which clears them.
- All mod_mult_p operands are < P, and every result is reduced to < P.
- Latency:
  - Invalid encoding: Done exactly 2 cycles after the Start cycle.
  - Valid key: 2 + (number of multiplies) × (mod_mult_p latency + 1) + 3.
  - Multiply count = 2 (cube) + 253 squarings + popcount(E) − 1 multiplies + 1 (verify).

Decomposition:
- Shared package elliptic_curve_structs holds:
  - curve_point_t;
  - localparams P (secp256k1 prime), CURVE_B = 7, and SQRT_EXP = (P+1)/4;
  - the SEC1 prefix constants PFX_EVEN = 8'h02 and PFX_ODD = 8'h03.
- Sub-module mod_mult_p computes a*b mod P with a start/done handshake and is shared with point_add and point_double.
- Registers use reg_256 (parameterized width).

Test Plan:
- Generator G, prefix 0x02, x = 79BE667E F9DCBBAC 55A06295 CE870B07 029BFCDB 2DCE28D9 59F2815B 16F81798 -> Valid=1, y = 483ADA77 26A3C465 5DA4FBFC 0E1108A8 FD17B448 A6855419 9C47D08F FB10D4B8.
- Same x, prefix 0x03 -> Valid=1, y = B7C52588 D95C3B9A A25B0403 F1EEF757 02E84BB7 597AABE6 63B82F6F 04EF2777.
- Bad encodings -> Done 2 cycles after Start, Valid=0, out_point=0:
  - prefix 0x04 with G.x;
  - prefix 0x02 with x = P;
  - prefix 0x02 with x = 2^256−1.
- x for which x^3+7 is a non-residue (bench computes it with a reference model) -> Valid=0 after the full latency; Busy falls on the Done cycle.
- Assert Reset in the 100th cycle of exponentiation -> outputs 0 the next cycle, no Done. A fresh Start with G then decodes correctly.
- Start pulsed again mid-operation with different data -> ignored; the result still matches the first request.
